parking_meter_timer: RTL

PARKING_METER_TIMER -- requirements
Module: parking_meter_timer

---
 rtl/meter_pkg.sv | 26 ++
 rtl/bin_to_bcd.sv | 32 +++
 rtl/parking_meter_timer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/meter_pkg.sv
// Shared sizing helpers for the parking meter: display range, register widths, BCD digit width.
package meter_pkg;

    localparam int BCD_W = 4;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Largest count the display can show, e.g. 9999 for four digits.
    function automatic int max_count(input int digits);
        return pow10(digits) - 1;
    endfunction

    // Bits needed to hold values 0..v-1; never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational double-dabble binary to BCD converter, DIGITS digits, digit 0 in the low nibble.
// Zero latency; no handshake.
module bin_to_bcd
    import meter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = clog2(max_count(DIGITS) + 1)
)(
    input  logic [BIN_W-1:0]          bin_i,
    output logic [BCD_W*DIGITS-1:0]   bcd_o
);

    localparam int SW = BIN_W + BCD_W * DIGITS;

    logic [SW-1:0] sh;

    always_comb begin
        sh = '0;
        sh[BIN_W-1:0] = bin_i;
        for (int b = 0; b < BIN_W; b++) begin
            // Pre-correct any digit >= 5 so the following shift carries into the next digit.
            for (int d = 0; d < DIGITS; d++) begin
                if (sh[BIN_W + BCD_W*d +: BCD_W] >= 4'd5)
                    sh[BIN_W + BCD_W*d +: BCD_W] = sh[BIN_W + BCD_W*d +: BCD_W] + 4'd3;
            end
            sh = sh << 1;
        end
    end

    assign bcd_o = sh[BIN_W +: BCD_W*DIGITS];

endmodule

// File: rtl/parking_meter_timer.sv
// Parking meter countdown: coin adds and presets load a saturating seconds count, decremented each prescaler tick.
// Status and BCD display are registered one cycle behind the count; no backpressure, inputs are single-cycle pulses/levels.
module parking_meter_timer
    import meter_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int TICK_DIV   = 100000000,
    parameter int ADD0       = 30,
    parameter int ADD1       = 120,
    parameter int ADD2       = 180,
    parameter int ADD3       = 300,
    parameter int PRESET_A   = 15,
    parameter int PRESET_B   = 185,
    parameter int LOW_THRESH = 200
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                add_req,
    input  logic                      preset_a,
    input  logic                      preset_b,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      expired,
    output logic                      low_time,
    output logic                      disp_en,
    output logic                      tick
);

    localparam int MAX = max_count(DIGITS);
    localparam int CW  = clog2(MAX + 1);
    localparam int PW  = clog2(TICK_DIV);

    localparam logic [CW-1:0] MAX_C   = CW'(MAX);
    localparam logic [CW-1:0] PRE_A_C = CW'((PRESET_A > MAX) ? MAX : PRESET_A);
    localparam logic [CW-1:0] PRE_B_C = CW'((PRESET_B > MAX) ? MAX : PRESET_B);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PS_HALF = PW'(TICK_DIV / 2);

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PW-1:0]             presc_q, presc_d;
    logic                      phase_q, phase_d;
    logic [BCD_W*DIGITS-1:0]   bcd_q;
    logic                      expired_q, low_q;

    logic                      preset_any;
    logic                      tick_run;
    logic [31:0]               sum_w;
    logic [CW-1:0]             s_c;
    logic [BCD_W*DIGITS-1:0]   bcd_c;
    logic                      is_low;

    assign tick       = (presc_q == PS_LAST);
    assign preset_any = preset_a | preset_b;
    assign tick_run   = tick & ~preset_any;
    assign is_low     = (cnt_q != '0) && (32'(cnt_q) < LOW_THRESH);

    // All add bits in one cycle are summed before saturating, so a simultaneous burst can never wrap.
    always_comb begin
        sum_w = 32'(cnt_q);
        if (add_req[0]) sum_w = sum_w + 32'(ADD0);
        if (add_req[1]) sum_w = sum_w + 32'(ADD1);
        if (add_req[2]) sum_w = sum_w + 32'(ADD2);
        if (add_req[3]) sum_w = sum_w + 32'(ADD3);
        s_c = (sum_w > 32'(MAX)) ? MAX_C : sum_w[CW-1:0];
    end

    always_comb begin
        cnt_d   = cnt_q;
        presc_d = presc_q;
        phase_d = phase_q;
        if (preset_a) begin
            cnt_d   = PRE_A_C;
            presc_d = '0;
        end else if (preset_b) begin
            cnt_d   = PRE_B_C;
            presc_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            cnt_d   = (tick && (s_c != '0)) ? s_c - CW'(1) : s_c;
        end
        // Held at 1 while time remains, so the blink always starts lit on entering expiry.
        if (cnt_q != '0)
            phase_d = 1'b1;
        else if (tick_run)
            phase_d = ~phase_q;
    end

    bin_to_bcd #(
        .DIGITS (DIGITS),
        .BIN_W  (CW)
    ) u_bin_to_bcd (
        .bin_i  (cnt_q),
        .bcd_o  (bcd_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            presc_q   <= '0;
            phase_q   <= 1'b1;
            bcd_q     <= '0;
            expired_q <= 1'b1;
            low_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            bcd_q     <= bcd_c;
            expired_q <= (cnt_q == '0);
            low_q     <= is_low;
        end
    end

    always_comb begin
        disp_en = 1'b1;
        if (cnt_q == '0)
            disp_en = phase_q;
        else if (is_low)
            disp_en = (presc_q < PS_HALF);
    end

    assign bcd_out  = bcd_q;
    assign expired  = expired_q;
    assign low_time = low_q;

endmodule
